// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  localparam int unsigned ACC_LEN = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port, one outstanding access.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = ACC_LEN * 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic              if_rsp_valid_q, ls_rsp_valid_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  owner_e            grant;
  logic              pref_ls;

`ifdef MEM_ARB_RR_EN
  owner_e rr_q, rr_d;
  assign pref_ls = (rr_q == OWN_LS);
`else
  assign pref_ls = 1'b1;
`endif

  // Grant, request-side handshake and next state; nothing here reads mem_rsp_valid/mem_rdata
  // except the BUSY exit, which only feeds registers.
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wr        = 1'b0;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_d          = rr_q;
`endif
    grant = (ls_req_valid && (!if_req_valid || pref_ls)) ? OWN_LS : OWN_IF;

    case (state_q)
      IDLE: begin
        mem_req_valid = if_req_valid | ls_req_valid;
        if (mem_req_valid) begin
          if (grant == OWN_LS) begin
            mem_addr     = ls_addr;
            mem_wr       = ls_wr;
            mem_wdata    = ls_wr ? ls_wdata : '0;
            ls_req_ready = mem_req_ready;
          end else begin
            mem_addr     = if_addr;
            if_req_ready = mem_req_ready;
          end
          if (mem_req_ready) begin
            state_d = (grant == OWN_LS) ? BUSY_LS : BUSY_IF;
            store_d = (grant == OWN_LS) && ls_wr;
`ifdef MEM_ARB_RR_EN
            rr_d    = (grant == OWN_LS) ? OWN_IF : OWN_LS;
`endif
          end
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      store_q        <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rdata_q     <= '0;
      ls_rdata_q     <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q           <= OWN_LS;
`endif
    end else begin
      state_q        <= state_d;
      store_q        <= store_d;
      if_rsp_valid_q <= (state_q == BUSY_IF) && mem_rsp_valid;
      ls_rsp_valid_q <= (state_q == BUSY_LS) && mem_rsp_valid;
      if ((state_q == BUSY_IF) && mem_rsp_valid) if_rdata_q <= mem_rdata;
      if ((state_q == BUSY_LS) && mem_rsp_valid) ls_rdata_q <= store_q ? '0 : mem_rdata;
`ifdef MEM_ARB_RR_EN
      rr_q           <= rr_d;
`endif
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; fixed access length 4 bytes.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 if_req_valid  input  1  instruction-fetch request.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_addr  input  ADDR_W  fetch address (pc).
REQ-008 if_rsp_valid  output  1  fetch data valid, one-cycle pulse.
REQ-009 if_rdata  output  DATA_W  fetched instruction.
REQ-010 ls_req_valid  input  1  load/store request.
REQ-011 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-012 ls_wr  input  1  1 = store, 0 = load.
REQ-013 ls_addr  input  ADDR_W  data address (alu result).
REQ-014 ls_wdata  input  DATA_W  store data.
REQ-015 ls_rsp_valid  output  1  load data / store ack, one-cycle pulse.
REQ-016 ls_rdata  output  DATA_W  load data; 0 for store ack.
REQ-017 mem_req_valid  output  1  request to shared memory port.
REQ-018 mem_req_ready  input  1  memory accepts request.
REQ-019 mem_addr, mem_wdata, mem_wr  output  ADDR_W/DATA_W/1  forwarded from granted requester.
REQ-020 mem_rsp_valid  input  1  memory response, ≥1 cycle after acceptance.
REQ-021 mem_rdata  input  DATA_W  memory read data.

Function
REQ-022 FSM states SHALL be IDLE, BUSY_IF, BUSY_LS; at most one memory transaction outstanding.
REQ-023 IDLE: mem_req_valid = if_req_valid | ls_req_valid; mem_addr/mem_wdata/mem_wr driven from granted requester combinationally.
REQ-024 Default arbitration: ls wins when both valid (fixed priority).
REQ-025 Grant handshake: granted x_req_ready = mem_req_ready in IDLE; non-granted ready = 0.
REQ-026 IDLE & mem_req_valid & mem_req_ready -> BUSY_IF or BUSY_LS per grant; owner latched.
REQ-027 BUSY_*: mem_req_valid = 0, both req_ready = 0; requests held by requesters.
REQ-028 BUSY_* & mem_rsp_valid -> IDLE; owner's rsp_valid pulses next cycle with registered mem_rdata (ls store: rdata 0).
REQ-029 Throughput: new request may be issued in the cycle the response pulse is visible; max 1 transaction per 2 cycles with 1-cycle memory.
REQ-030 mem_rsp_valid in IDLE (spurious/stale) SHALL be ignored; no rsp pulse.
REQ-031 No combinational path from mem_rsp_valid/mem_rdata to any req-side output.
REQ-032 mem_wr SHALL be 0 whenever if is granted; mem_wdata 0 when not a store.

Reset
REQ-033 rst_n low at a clock edge: state IDLE, owner cleared, if_rsp_valid = ls_rsp_valid = 0, rdata regs 0, RR pointer -> ls.
REQ-034 Reset mid-transaction abandons owner; subsequent response dropped per REQ-030.

Configuration
REQ-035 MEM_ARB_RR_EN defined: round-robin when both valid — pointer toggles to other requester after each granted handshake; undefined: fixed priority per REQ-024, no pointer state.

Structure
REQ-036 Shared package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_LS), owner enum (OWN_IF, OWN_LS), ACC_LEN = 4.
REQ-037 Single module, no sub-module; grant logic as one combinational process.

Verification
REQ-038 if only, addr 0x8000_0000, mem_rsp 1 cycle later rdata 0x0000_0013 -> if_rsp_valid pulse, if_rdata 0x13, ls_rsp_valid 0.
REQ-039 Both valid same cycle, ls load 0x100 -> ls granted first; if granted after ls_rsp; fixed mode: ls again if still valid.
REQ-040 MEM_ARB_RR_EN, both continuously valid 4 transactions -> grant order ls, if, ls, if.
REQ-041 ls store addr 0x200 wdata 0xDEAD_BEEF, mem_req_ready low 3 cycles -> mem_wr=1, ls_req_ready low until ready, ack pulse with ls_rdata 0.
REQ-042 rst_n low during BUSY_LS, stale mem_rsp_valid after release -> no rsp pulse, state IDLE, next if request served normally.
REQ-043 mem_rsp_valid while IDLE with no outstanding -> no rsp pulse, state unchanged.
